// File: rtl/mem_load_store_unit.sv
// Load/store unit bridging a 32-bit pipeline port to a byte-wide, big-endian memory bus.
// Requests are either faulted immediately or serialised into one bus strobe per byte.
module mem_load_store_unit #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  load_mode,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] bus_addr,
    output logic        bus_re,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] MODE_WORD  = 2'b00;
    localparam logic [1:0] MODE_HALFS = 2'b01;
    localparam logic [1:0] MODE_HALFU = 2'b10;
    localparam logic [1:0] MODE_ILL   = 2'b11;

    state_t      state;
    logic [1:0]  mode_q;
    logic        is_store;
    logic [2:0]  cnt;
    logic [23:0] wd_sh;
    logic [23:0] rx_sh;

    logic        req;
    logic        word_req;
    logic        half_req;
    logic        illegal;
    logic [2:0]  load_last;
    logic [31:0] assembled;

    // Request decode for the acceptance cycle.
    always_comb begin
        req      = mem_read | mem_write;
        word_req = mem_write | (mem_read & (load_mode == MODE_WORD));
        half_req = mem_read & ~mem_write &
                   ((load_mode == MODE_HALFS) | (load_mode == MODE_HALFU));
        illegal  = (mem_read & mem_write) | (mem_read & (load_mode == MODE_ILL));
        if (ALIGN_CHECK && word_req && (address[1:0] != 2'b00))
            illegal = 1'b1;
        if (ALIGN_CHECK && half_req && address[0])
            illegal = 1'b1;
    end

    // NOTE: every signal written in an always_comb gets a value on every path
    // (here via the leading defaults), otherwise synthesis infers a latch.
    always_comb begin
        stall = 1'b0;
        if (!reset)
            stall = ((state == IDLE) && req) || (state == ACCESS);
    end

    // A load's ACCESS phase runs cnt = 0..n, the extra cycle collecting the last byte.
    always_comb begin
        load_last = (mode_q == MODE_WORD) ? 3'd4 : 3'd2;
        case (mode_q)
            MODE_HALFS: assembled = {{16{rx_sh[7]}}, rx_sh[7:0], bus_rdata};
            MODE_HALFU: assembled = {16'h0000, rx_sh[7:0], bus_rdata};
            default:    assembled = {rx_sh, bus_rdata};
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= MODE_WORD;
            is_store  <= 1'b0;
            cnt       <= 3'd0;
            wd_sh     <= 24'h0;
            rx_sh     <= 24'h0;
            read_data <= 32'h0;
            done      <= 1'b0;
            fault     <= 1'b0;
            bus_addr  <= 32'h0;
            bus_re    <= 1'b0;
            bus_we    <= 1'b0;
            bus_wdata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        mode_q   <= load_mode;
                        is_store <= mem_write;
                        cnt      <= 3'd0;
                        if (illegal) begin
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else begin
                            state    <= ACCESS;
                            bus_addr <= address;
                            if (mem_write) begin
                                bus_we    <= 1'b1;
                                bus_wdata <= write_data[31:24];
                                wd_sh     <= write_data[23:0];
                            end else begin
                                bus_re <= 1'b1;
                            end
                        end
                    end
                end

                ACCESS: begin
                    if (is_store) begin
                        if (cnt == 3'd3) begin
                            bus_we <= 1'b0;
                            cnt    <= 3'd0;
                            state  <= DONE;
                            done   <= 1'b1;
                        end else begin
                            cnt       <= cnt + 3'd1;
                            bus_addr  <= bus_addr + 32'd1;
                            bus_wdata <= wd_sh[23:16];
                            wd_sh     <= {wd_sh[15:0], 8'h00};
                        end
                    end else begin
                        if (cnt == load_last) begin
                            bus_re    <= 1'b0;
                            read_data <= assembled;
                            cnt       <= 3'd0;
                            state     <= DONE;
                            done      <= 1'b1;
                        end else begin
                            // Byte k arrives in the cycle after its strobe.
                            if (cnt != 3'd0)
                                rx_sh <= {rx_sh[15:0], bus_rdata};
                            cnt <= cnt + 3'd1;
                            if ((cnt + 3'd1) < load_last) begin
                                bus_re   <= 1'b1;
                                bus_addr <= bus_addr + 32'd1;
                            end else begin
                                bus_re <= 1'b0;
                            end
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
